// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined IEEE-754 adder/subtractor with RNE rounding,
// special-case handling and {invalid, overflow, underflow, inexact} flags.
// Optional macro FP_ADDSUB_SUBNORMAL_EN: full subnormal support; when undefined,
// subnormal inputs and tiny results are flushed to signed zero.
module fp_addsub_pipe #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);
  localparam int unsigned SIG = MAN_W + 1;
  localparam int unsigned EW  = MAN_W + 4;
  localparam int unsigned EE  = EXP_W + 2;
  localparam int unsigned LZW = $clog2(EW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  logic             w_as, w_bs;
  logic [EXP_W-1:0] w_ae, w_be, w_a_ee, w_b_ee;
  logic [MAN_W-1:0] w_af, w_bf;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  logic             w_a_zero, w_b_zero, w_a_hid, w_b_hid;

  assign w_as = a[WIDTH-1];
  assign w_ae = a[WIDTH-2 -: EXP_W];
  assign w_af = a[MAN_W-1:0];
  assign w_bs = b[WIDTH-1] ^ subtract;
  assign w_be = b[WIDTH-2 -: EXP_W];
  assign w_bf = b[MAN_W-1:0];

  assign w_a_nan  = (w_ae == EXP_MAX) && (w_af != '0);
  assign w_b_nan  = (w_be == EXP_MAX) && (w_bf != '0);
  assign w_a_snan = w_a_nan && !w_af[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_bf[MAN_W-1];
  assign w_a_inf  = (w_ae == EXP_MAX) && (w_af == '0);
  assign w_b_inf  = (w_be == EXP_MAX) && (w_bf == '0);
`ifdef FP_ADDSUB_SUBNORMAL_EN
  assign w_a_zero = (w_ae == '0) && (w_af == '0);
  assign w_b_zero = (w_be == '0) && (w_bf == '0);
  assign w_a_hid  = (w_ae != '0);
  assign w_b_hid  = (w_be != '0);
  assign w_a_ee   = (w_ae != '0) ? w_ae : EXP_W'(1);
  assign w_b_ee   = (w_be != '0) ? w_be : EXP_W'(1);
`else
  assign w_a_zero = (w_ae == '0);
  assign w_b_zero = (w_be == '0);
  assign w_a_hid  = 1'b1;
  assign w_b_hid  = 1'b1;
  assign w_a_ee   = w_ae;
  assign w_b_ee   = w_be;
`endif

  logic             w_a_big, w_l_s, w_eff_sub, w_spec, w_spec_inv;
  logic [EXP_W-1:0] w_l_e, w_d;
  logic [SIG-1:0]   w_s_sig;
  logic [EW-1:0]    w_ml, w_ms, w_s_ext;
  logic [WIDTH-1:0] w_spec_y;

  // Stage 1: swap by magnitude, align the smaller operand with sticky, resolve specials.
  always_comb begin
    w_a_big   = {w_ae, w_af} >= {w_be, w_bf};
    w_l_s     = w_a_big ? w_as : w_bs;
    w_l_e     = w_a_big ? w_a_ee : w_b_ee;
    w_d       = w_a_big ? (w_a_ee - w_b_ee) : (w_b_ee - w_a_ee);
    w_ml      = w_a_big ? {w_a_hid, w_af, 3'b000} : {w_b_hid, w_bf, 3'b000};
    w_s_sig   = w_a_big ? {w_b_hid, w_bf} : {w_a_hid, w_af};
    w_s_ext   = {w_s_sig, 3'b000};
    w_eff_sub = w_as ^ w_bs;
    if (32'(w_d) >= EW - 1) w_ms = {{(EW-1){1'b0}}, |w_s_sig};
    else w_ms = (w_s_ext >> w_d) | EW'(|(w_s_ext & ~({EW{1'b1}} << w_d)));

    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_y   = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub)) begin
      w_spec_y   = QNAN;
      w_spec_inv = w_a_snan || w_b_snan || (w_a_inf && w_b_inf);
    end else if (w_a_inf) w_spec_y = {w_as, EXP_MAX, {MAN_W{1'b0}}};
    else if (w_b_inf) w_spec_y = {w_bs, EXP_MAX, {MAN_W{1'b0}}};
    else if (w_a_zero && w_b_zero) w_spec_y = {w_as & w_bs, {(WIDTH-1){1'b0}}};
    else if (w_b_zero) w_spec_y = a;
    else if (w_a_zero) w_spec_y = {w_bs, b[WIDTH-2:0]};
    else w_spec = 1'b0;
  end

  logic             r1_valid, r1_spec, r1_spec_inv, r1_sign, r1_sub;
  logic [WIDTH-1:0] r1_spec_y;
  logic [EXP_W-1:0] r1_exp;
  logic [EW-1:0]    r1_ml, r1_ms;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_spec     <= w_spec;
      r1_spec_inv <= w_spec_inv;
      r1_spec_y   <= w_spec_y;
      r1_sign     <= w_l_s;
      r1_sub      <= w_eff_sub;
      r1_exp      <= w_l_e;
      r1_ml       <= w_ml;
      r1_ms       <= w_ms;
    end
  end

  logic [EW:0]    w_sum;
  logic [LZW-1:0] w_lzc;

  // Stage 2: magnitude add/subtract and leading-zero count.
  always_comb begin
    if (r1_sub) w_sum = {1'b0, r1_ml} - {1'b0, r1_ms};
    else        w_sum = {1'b0, r1_ml} + {1'b0, r1_ms};
    w_lzc = LZW'(EW);
    for (int i = 0; i < int'(EW); i++) begin
      if (w_sum[i]) w_lzc = LZW'(int'(EW) - 1 - i);
    end
  end

  logic             r2_valid, r2_spec, r2_spec_inv, r2_sign;
  logic [WIDTH-1:0] r2_spec_y;
  logic [EXP_W-1:0] r2_exp;
  logic [EW:0]      r2_sum;
  logic [LZW-1:0]   r2_lzc;

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r2_valid <= 1'b0;
    end else if (w_adv) begin
      r2_valid    <= r1_valid;
      r2_spec     <= r1_spec;
      r2_spec_inv <= r1_spec_inv;
      r2_spec_y   <= r1_spec_y;
      r2_sign     <= r1_sign;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
      r2_lzc      <= w_lzc;
    end
  end

  logic [EW-1:0]        w_m;
  logic signed [EE-1:0] w_e0, w_lz, w_en, w_ef;
  logic                 w_tiny, w_inx, w_rup;
  logic [SIG:0]         w_mr;
  logic [EXP_W-1:0]     w_efield;
  logic [MAN_W-1:0]     w_frac;
  logic [WIDTH-1:0]     w_y;
  logic [3:0]           w_fl;
`ifdef FP_ADDSUB_SUBNORMAL_EN
  logic signed [EE-1:0] w_sh;
`endif

  // Stage 3: normalize, round to nearest even, detect overflow/underflow, pack.
  always_comb begin
    w_e0   = $signed(EE'(r2_exp));
    w_lz   = $signed(EE'(r2_lzc));
    w_tiny = 1'b0;
`ifdef FP_ADDSUB_SUBNORMAL_EN
    w_sh   = '0;
`endif
    if (r2_sum[EW]) begin
      w_m  = {r2_sum[EW:2], r2_sum[1] | r2_sum[0]};
      w_en = w_e0 + $signed(EE'(1));
    end else begin
      w_tiny = (w_e0 - w_lz) < $signed(EE'(1));
`ifdef FP_ADDSUB_SUBNORMAL_EN
      w_sh = w_tiny ? (w_e0 - $signed(EE'(1))) : w_lz;
      w_m  = r2_sum[EW-1:0] << w_sh;
      w_en = w_e0 - w_sh;
`else
      w_m  = r2_sum[EW-1:0] << r2_lzc;
      w_en = w_e0 - w_lz;
`endif
    end
    w_inx = |w_m[2:0];
    w_rup = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_mr  = {1'b0, w_m[EW-1:3]} + (SIG+1)'(w_rup);
    if (w_mr[SIG]) begin
      w_frac = w_mr[MAN_W:1];
      w_ef   = w_en + $signed(EE'(1));
    end else begin
      w_frac = w_mr[MAN_W-1:0];
      w_ef   = w_en;
    end
    // a result still lacking the hidden bit after rounding is subnormal
    w_efield = (w_mr[SIG] || w_mr[SIG-1]) ? w_ef[EXP_W-1:0] : '0;

    w_y  = {r2_sign, w_efield, w_frac};
    w_fl = {2'b00, w_tiny & w_inx, w_inx};
    if (r2_spec) begin
      w_y  = r2_spec_y;
      w_fl = {r2_spec_inv, 3'b000};
    end else if (r2_sum == '0) begin
      w_y  = '0;
      w_fl = '0;
`ifndef FP_ADDSUB_SUBNORMAL_EN
    end else if (w_tiny) begin
      w_y  = {r2_sign, {(WIDTH-1){1'b0}}};
      w_fl = 4'b0011;
`endif
    end else if (w_ef >= $signed(EE'(EXP_MAX))) begin
      w_y  = {r2_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_fl = 4'b0101;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
    end else if (w_adv) begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        y     <= w_y;
        flags <= w_fl;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (default build, subnormals flushed).
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, subtract, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_pass = 0;
  int stall_seen = 0;

  typedef struct packed {logic [31:0] y; logic [3:0] fl;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic sub; logic [31:0] y; logic [3:0] fl;} vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[21];
  logic [31:0] bp_a[6];
  logic [31:0] bp_y[6];

  logic        held = 1'b0;
  logic [31:0] held_y;
  logic [3:0]  held_fl;

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .subtract(subtract), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .flags(flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Output monitor: scoreboard compare, hold stability, in_ready while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      if (held && out_valid) begin
        chk("hold_y", y, held_y);
        chk("hold_flags", 32'(flags), 32'(held_fl));
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk("in_ready_stall", 32'(in_ready), 32'(0));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got y=%h flags=%b, required no output", y, flags);
        end else begin
          mon_e = sb_q.pop_front();
          chk("y", y, mon_e.y);
          chk("flags", 32'(flags), 32'(mon_e.fl));
        end
      end
    end
    held    <= !reset && out_valid && !out_ready;
    held_y  <= y;
    held_fl <= flags;
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                      input logic [31:0] ey, input logic [3:0] ef);
    bit ok;
    int n;
    n = 0;
    a = ta; b = tb; subtract = ts; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (ok) sb_q.push_back({ey, ef});
    else begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic latency_checks();
    @(negedge clk); chk("lat_c1", 32'(out_valid), 32'(0));
    @(negedge clk); chk("lat_c2", 32'(out_valid), 32'(0));
    @(negedge clk); chk("lat_c3", 32'(out_valid), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; subtract = 1'b0; out_ready = 1'b1;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    vecs[4]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[7]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    vecs[8]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vecs[10] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[11] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
    vecs[12] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[13] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[14] = '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'b0000};
    vecs[15] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
    vecs[16] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000};
    vecs[17] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
    vecs[18] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[19] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101};
    vecs[20] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000};

    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_y = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_y", y, 32'h0);
    chk("reset_flags", 32'(flags), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));

    // Basic add with exact latency.
    @(posedge clk); #1;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    latency_checks();
    drain();

    // Vector table, issued back to back.
    for (int i = 0; i < 21; i++) send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].y, vecs[i].fl);
    drain();

    // Backpressure: out_ready low for stream cycles 2..7.
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_a[i], 32'h3F800000, 1'b0, bp_y[i], 4'b0000);
      end
      begin
        for (int c = 1; c <= 8; c++) begin
          out_ready = !(c >= 2 && c <= 7);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_observed", 32'(stall_seen > 0), 32'(1));

    // Reset while two beats are in flight; neither may appear.
    @(posedge clk); #1;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    latency_checks();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
